pmem_arbiter: RTL and testbench

Arbitrates the instruction-cache and data-cache physical-memory ports onto a single physical-memory port. It sits directly downstream of the two cache controllers, whose `pmem_read`/`pmem_write` are level requests held until `pmem_resp`. It latches one request at grant and holds it stable on the memory port. Simultaneous requests are resolved round-robin. If a client abandons a request mid-transaction, the memory transaction still completes safely.

---
 rtl/pmem_arbiter_if.sv | 41 ++++
 rtl/pmem_arbiter.sv | 111 +++++++++++
 tb/tb_pmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Groups the I-cache, D-cache and physical-memory ports of pmem_arbiter.
// The arbiter uses the slave view; the surrounding caches and memory use the master view.
interface pmem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 256
);
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_address;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;
   logic                  i_pmem_resp;

   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_address;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;
   logic                  d_pmem_resp;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  mem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  mem_rdata, mem_resp,
      output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
      output mem_read, mem_write, mem_address, mem_wdata
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output mem_rdata, mem_resp,
      input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
      input  mem_read, mem_write, mem_address, mem_wdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter merging the I-cache and D-cache pmem ports onto one memory port.
// The granted command is latched and held until memory responds, even if the client gives up.
module pmem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 256
) (
   input logic           clk,
   input logic           reset,
   pmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle,
      StServeI,
      StServeD,
      StDrain
   } state_e;

   state_e                state_q, state_d;
   logic                  last_d_q, last_d_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;

   logic i_req, d_req, grant_i;
   logic i_resp, d_resp;
   logic active;

   assign i_req   = bus.i_pmem_read;
   assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
   // On a tie, the client that was not served last wins.
   assign grant_i = i_req & (~d_req | last_d_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         last_d_q <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (grant_i) begin
               state_d  = StServeI;
               last_d_d = 1'b0;
               addr_d   = bus.i_pmem_address;
               wdata_d  = '0;
               write_d  = 1'b0;
            end else if (d_req) begin
               state_d  = StServeD;
               last_d_d = 1'b1;
               addr_d   = bus.d_pmem_address;
               wdata_d  = bus.d_pmem_wdata;
               write_d  = bus.d_pmem_write;
            end
         end
         StServeI: begin
            if (bus.mem_resp) begin
               state_d = StIdle;
               i_resp  = i_req;
            end else if (!i_req) begin
               state_d = StDrain;
            end
         end
         StServeD: begin
            if (bus.mem_resp) begin
               state_d = StIdle;
               d_resp  = d_req;
            end else if (!d_req) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // The abandoned command must still finish before memory is reused.
            if (bus.mem_resp) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign active = (state_q != StIdle);

   assign bus.mem_read     = active & ~write_q;
   assign bus.mem_write    = active & write_q;
   assign bus.mem_address  = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.i_pmem_resp  = i_resp;
   assign bus.d_pmem_resp  = d_resp;
   assign bus.i_pmem_rdata = bus.mem_rdata;
   assign bus.d_pmem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed scenarios followed by randomized client and
// memory traffic, checked against a transaction-level model of the arbitration rules.
module tb_pmem_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   typedef struct {
      bit            is_d;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      bit            write;
   } txn_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   i_got, d_got;
   int   i_resp_cyc, d_resp_cyc;
   int   fixed_lat = 3;
   bit   spurious = 1'b0;
   txn_t exp_q[$];
   bit   last_d = 1'b1;
   bit   abandoned = 1'b0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] r;
      for (int k = 0; k < int'(LW / 32); k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      logic [AW-1:0] a;
      a = $urandom;
      return a & ~32'h1F;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor and reference model: checks this cycle, then advances the model to the next edge.
   always @(negedge clk) begin : mon
      txn_t t;
      bit   busy, owner_req, i_req, d_req, gd;
      i_got <= bus.i_pmem_resp;
      d_got <= bus.d_pmem_resp;
      if (bus.i_pmem_resp) i_resp_cyc <= cyc;
      if (bus.d_pmem_resp) d_resp_cyc <= cyc;
      if (!reset) begin
         exp_q.delete();
         last_d    = 1'b1;
         abandoned = 1'b0;
      end else begin
         i_req = bus.i_pmem_read;
         d_req = bus.d_pmem_read | bus.d_pmem_write;
         busy  = (exp_q.size() != 0);
         t     = '{default: 0};
         if (busy) t = exp_q[0];
         owner_req = busy && (t.is_d ? d_req : i_req);
         check("mem_read", bus.mem_read, busy && !t.write);
         check("mem_write", bus.mem_write, busy && t.write);
         if (busy) begin
            check("mem_address", bus.mem_address, t.addr);
            check("mem_wdata", bus.mem_wdata, t.wdata);
         end
         check("i_pmem_resp", bus.i_pmem_resp,
               busy && bus.mem_resp && !t.is_d && owner_req && !abandoned);
         check("d_pmem_resp", bus.d_pmem_resp,
               busy && bus.mem_resp && t.is_d && owner_req && !abandoned);
         check("i_pmem_rdata", bus.i_pmem_rdata, bus.mem_rdata);
         check("d_pmem_rdata", bus.d_pmem_rdata, bus.mem_rdata);
         if (busy) begin
            if (!owner_req) abandoned = 1'b1;
            if (bus.mem_resp) begin
               void'(exp_q.pop_front());
               abandoned = 1'b0;
            end
         end else if (i_req || d_req) begin
            gd = d_req && (!i_req || !last_d);
            t.is_d  = gd;
            t.addr  = gd ? bus.d_pmem_address : bus.i_pmem_address;
            t.wdata = gd ? bus.d_pmem_wdata : '0;
            t.write = gd && bus.d_pmem_write;
            exp_q.push_back(t);
            last_d = gd;
         end
      end
   end

   // Physical memory: responds after fixed_lat extra cycles (random when negative).
   initial begin : memory
      int mem_cnt;
      int mem_lat;
      mem_cnt = 0;
      mem_lat = 0;
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            bus.mem_resp = 1'b0;
            mem_cnt      = 0;
         end else if (bus.mem_read || bus.mem_write) begin
            if (mem_cnt == 0) mem_lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 5);
            if (mem_cnt >= mem_lat) begin
               bus.mem_resp  = 1'b1;
               bus.mem_rdata = rnd_line();
               mem_cnt       = 0;
            end else begin
               bus.mem_resp = 1'b0;
               mem_cnt++;
            end
         end else begin
            bus.mem_resp = spurious && ($urandom_range(0, 7) == 0);
            if (bus.mem_resp) bus.mem_rdata = rnd_line();
            mem_cnt = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_got(input bit want_d, input int bound, input string name);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(want_d ? d_got : i_got) && n < bound);
      if (!(want_d ? d_got : i_got)) begin
         checks++;
         errors++;
         $display("FAIL %s: no response within %0d cycles", name, bound);
      end
   endtask

   task automatic drop_all();
      bus.i_pmem_read  = 1'b0;
      bus.d_pmem_read  = 1'b0;
      bus.d_pmem_write = 1'b0;
   endtask

   // Called between clock edges: reset must clear the memory port without any edge.
   task automatic async_reset(input string name);
      reset = 1'b0;
      drop_all();
      #1;
      check({name, "_mem_read"}, bus.mem_read, 1'b0);
      check({name, "_mem_write"}, bus.mem_write, 1'b0);
      check({name, "_i_resp"}, bus.i_pmem_resp, 1'b0);
      check({name, "_d_resp"}, bus.d_pmem_resp, 1'b0);
      check({name, "_mem_address"}, bus.mem_address, '0);
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic random_step();
      int r;
      if (!bus.i_pmem_read || i_got) begin
         bus.i_pmem_read    = ($urandom_range(0, 2) == 0);
         bus.i_pmem_address = rnd_addr();
      end else if ($urandom_range(0, 39) == 0) begin
         bus.i_pmem_read = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
         bus.i_pmem_address = rnd_addr();
      end
      if (!(bus.d_pmem_read || bus.d_pmem_write) || d_got) begin
         r = $urandom_range(0, 9);
         bus.d_pmem_read    = (r < 2) || (r == 4);
         bus.d_pmem_write   = (r == 2) || (r == 3) || (r == 4);
         bus.d_pmem_address = rnd_addr();
         bus.d_pmem_wdata   = rnd_line();
      end else if ($urandom_range(0, 39) == 0) begin
         bus.d_pmem_read  = 1'b0;
         bus.d_pmem_write = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
         bus.d_pmem_address = rnd_addr();
         bus.d_pmem_wdata   = rnd_line();
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [AW-1:0] ia, da;
      logic [LW-1:0] wb;
      int req_cyc, i_first;
      bit found;
      drop_all();
      bus.i_pmem_address = '0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      wb = {16{16'h1234}};
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Tie straight after reset: I first, then D after one idle bubble.
      tick();
      ia = 32'h0000_2000;
      da = 32'h0000_3000;
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = ia;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = da;
      wait_got(1'b0, 20, "tie_i_resp");
      bus.i_pmem_read = 1'b0;
      i_first = i_resp_cyc;
      tick();
      check("tie_switch_address", bus.mem_address, da);
      check("tie_switch_read", bus.mem_read, 1'b1);
      wait_got(1'b1, 20, "tie_d_resp");
      bus.d_pmem_read = 1'b0;
      check("tie_d_latency", d_resp_cyc - i_first, 5);

      // Single I read.
      tick();
      req_cyc = cyc;
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_1000;
      wait_got(1'b0, 20, "single_i_resp");
      bus.i_pmem_read = 1'b0;
      check("single_i_latency", i_resp_cyc - req_cyc, 4);
      check("single_i_idle_after", bus.mem_read, 1'b0);

      // D write-back with I pending, then D refill: I must slot in between.
      tick();
      bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h0000_4000; bus.d_pmem_wdata = wb;
      tick();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_5000;
      check("wb_mem_write", bus.mem_write, 1'b1);
      check("wb_mem_wdata", bus.mem_wdata, wb);
      wait_got(1'b1, 20, "wb_d_write_resp");
      bus.d_pmem_write = 1'b0; bus.d_pmem_read = 1'b1;
      wait_got(1'b0, 20, "wb_i_resp");
      bus.i_pmem_read = 1'b0;
      wait_got(1'b1, 20, "wb_d_read_resp");
      bus.d_pmem_read = 1'b0;
      check("wb_order", i_resp_cyc < d_resp_cyc, 1'b1);

      // D abandons two cycles into its transaction while I waits.
      fixed_lat = 6;
      tick();
      da = 32'h0000_6000;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = da;
      tick();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_7000;
      tick();
      bus.d_pmem_read = 1'b0;
      tick();
      check("abandon_mem_read", bus.mem_read, 1'b1);
      check("abandon_mem_address", bus.mem_address, da);
      wait_got(1'b0, 30, "abandon_i_resp");
      bus.i_pmem_read = 1'b0;

      // Read and write both high is a write.
      fixed_lat = 3;
      tick();
      bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1;
      bus.d_pmem_address = 32'h0000_8000; bus.d_pmem_wdata = rnd_line();
      tick();
      check("both_mem_write", bus.mem_write, 1'b1);
      check("both_mem_read", bus.mem_read, 1'b0);
      wait_got(1'b1, 20, "both_d_resp");
      drop_all();

      // Asynchronous reset while I's response pulse is live, then the first tie goes to I.
      fixed_lat = 2;
      tick();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_9000;
      found = 1'b0;
      for (int n = 0; n < 12 && !found; n++) begin
         @(posedge clk);
         #2;
         found = bus.i_pmem_resp;
      end
      check("reset_pre_i_resp", found, 1'b1);
      async_reset("reset_mid");
      ia = 32'h0000_A000;
      da = 32'h0000_B000;
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = ia;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = da;
      tick();
      check("reset_tie_address", bus.mem_address, ia);
      wait_got(1'b0, 20, "reset_tie_i_resp");
      bus.i_pmem_read = 1'b0;
      wait_got(1'b1, 20, "reset_tie_d_resp");
      drop_all();

      // Randomized traffic with random latencies, stray memory responses and mid-run resets.
      fixed_lat = -1;
      spurious  = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         tick();
         random_step();
         if (c == 1500 || c == 3000) begin
            #2;
            async_reset("reset_random");
         end
      end

      drop_all();
      spurious = 1'b0;
      for (int n = 0; n < 50 && (bus.mem_read || bus.mem_write); n++) tick();
      tick();
      check("final_idle", bus.mem_read || bus.mem_write, 1'b0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
